// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Target end of the CPU load/store interface. It accepts one word access at a
// time, waits LATENCY cycles, then returns a one-cycle ack. The ack carries
// either load data or an error flag. The RAM holds 2^ADDR_W 32-bit words and
// is cleared by reset.
//
// Handshake: a request transfers on a rising edge where req=1 and ready=1.
// ready depends only on the FSM state, so it is high only in IDLE. While a
// transaction is in flight the request inputs are ignored and may change.
// ack is high for exactly one cycle per accepted request, and err is
// meaningful only while ack=1.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset; aborts any transaction in flight
//   req        request valid
//   ready      responder idle and able to accept a request
//   we         1 = store, 0 = load
//   addr       byte address; must be word aligned and inside the RAM
//   be         store byte enables; bit i covers wdata[8i+7:8i]
//   wdata      store data
//   ack        one-cycle response strobe
//   rdata      load data, updated on each ack; 0 for stores and errors
//   err        access rejected (misaligned or out of range), valid with ack
//   fsm_state  current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [3:0]        lat_be;
    logic [31:0]       lat_wdata;
    logic [31:0]       mem [2**ADDR_W];

    // An access is rejected if it is not word aligned or lies above the RAM.
    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    assign ready     = (state == S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_be    <= 4'd0;
            lat_wdata <= 32'd0;
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_be    <= be;
                        lat_wdata <= wdata;
                        cnt       <= 4'(LATENCY);
                        if (LATENCY == 0) begin
                            // No wait states: the response is formed straight
                            // from the request at the acceptance edge, so ack
                            // still comes from a register.
                            state <= S_RESP;
                            ack   <= 1'b1;
                            err   <= bad_addr(addr);
                            rdata <= (bad_addr(addr) || we) ? 32'd0
                                                            : mem[word_idx(addr)];
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // Stores commit only after RESP, so the RAM here
                        // still matches its contents at the acceptance edge.
                        state <= S_RESP;
                        ack   <= 1'b1;
                        err   <= bad_addr(lat_addr);
                        rdata <= (bad_addr(lat_addr) || lat_we) ? 32'd0
                                                                : mem[word_idx(lat_addr)];
                    end
                end

                S_RESP: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                    if (lat_we && !bad_addr(lat_addr)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (lat_be[b]) begin
                                mem[word_idx(lat_addr)][8*b +: 8] <= lat_wdata[8*b +: 8];
                            end
                        end
                    end
                end

                default: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// ---------------------------------------------------------------------------
// Bench for dmem_responder. It has two instances that share clock and reset:
//   inst0: LATENCY=2
//   inst1: LATENCY=0
// The driver tasks issue requests. At acceptance they push the expected
// response into exp_q: instance, err, rdata and acceptance cycle. The expected
// value comes from a plain word-array model of the RAM. A negedge monitor pops
// an entry on every ack. It checks err, rdata, latency and ready against a
// busy flag, and checks that rdata holds and err stays low between acks.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_s   [2];
    logic        ready_s [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [3:0]  be_s    [2];
    logic [31:0] wdata_s [2];
    logic        ack_s   [2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];
    logic [1:0]  st_s    [2];

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut_l2 (
        .clock(clk), .reset(rst), .req(req_s[0]), .ready(ready_s[0]),
        .we(we_s[0]), .addr(addr_s[0]), .be(be_s[0]), .wdata(wdata_s[0]),
        .ack(ack_s[0]), .rdata(rdata_s[0]), .err(err_s[0]), .fsm_state(st_s[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut_l0 (
        .clock(clk), .reset(rst), .req(req_s[1]), .ready(ready_s[1]),
        .we(we_s[1]), .addr(addr_s[1]), .be(be_s[1]), .wdata(wdata_s[1]),
        .ack(ack_s[1]), .rdata(rdata_s[1]), .err(err_s[1]), .fsm_state(st_s[1])
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [65:0] exp_q[$];              // {inst, err, rdata, accept cycle}
    logic        busy       [2];
    logic [31:0] last_rdata [2];
    logic [31:0] model_mem  [2][1024];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got 0x%08h required 0x%08h", name, k, act, exp);
        end
    endfunction

    function automatic void fail_event(input string name, input int k);
        checks++;
        failures++;
        $display("FAIL %s inst%0d: event not allowed or not reached in time", name, k);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                logic [65:0] e;
                chk("ready", k, 32'(ready_s[k]), 32'(!busy[k]));
                if (ack_s[k]) begin
                    if (exp_q.size() == 0) begin
                        fail_event("unexpected_ack", k);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_inst", k, 32'(k), 32'(e[65]));
                        chk("err", k, 32'(err_s[k]), 32'(e[64]));
                        chk("rdata", k, rdata_s[k], e[63:32]);
                        chk("latency", k, 32'(cyc) - e[31:0], 32'(lat_of(k)));
                        last_rdata[k] = e[63:32];
                        busy[k] = 1'b0;
                    end
                end else begin
                    chk("err_without_ack", k, 32'(err_s[k]), 32'd0);
                    chk("rdata_hold", k, rdata_s[k], last_rdata[k]);
                end
            end
        end
    end

    // Driver tasks. They are entered and left 1 time unit after a rising edge.
    task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d, input bit hold);
        int          n = 0;
        logic        e;
        logic [31:0] r;
        while (ready_s[k] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            fail_event("ready_timeout", k);
            return;
        end
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; be_s[k] = b; wdata_s[k] = d;
        @(posedge clk); #1;
        e = (a % 4 != 0) || (a >= 32'd4096);
        r = (e || w) ? 32'd0 : model_mem[k][a / 4];
        if (w && !e) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) model_mem[k][a / 4][8*i +: 8] = d[8*i +: 8];
            end
        end
        exp_q.push_back({k[0], e, r, 32'(cyc)});
        busy[k] = 1'b1;
        if (!hold) begin
            req_s[k]   = 1'b0;
            we_s[k]    = 1'($urandom);
            addr_s[k]  = $urandom;
            be_s[k]    = 4'($urandom);
            wdata_s[k] = $urandom;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail_event("drain_timeout", 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            busy[k] = 1'b0;
            last_rdata[k] = 32'd0;
            req_s[k] = 1'b0;
            for (int i = 0; i < 1024; i++) model_mem[k][i] = 32'd0;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", k, 32'(ready_s[k]), 32'd1);
            chk("reset_ack", k, 32'(ack_s[k]), 32'd0);
            chk("reset_err", k, 32'(err_s[k]), 32'd0);
            chk("reset_rdata", k, rdata_s[k], 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'd0;
            be_s[k] = 4'd0; wdata_s[k] = 32'd0;
        end
        do_reset();

        // Idle load after reset
        do_txn(0, 1'b0, 32'h10, 4'hF, 32'd0, 1'b0);
        drain();

        // Store then load with LATENCY=2
        do_txn(0, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF, 1'b0);
        do_txn(0, 1'b0, 32'h4, 4'hF, 32'd0, 1'b0);
        drain();

        // Byte enables
        do_txn(0, 1'b1, 32'h8, 4'hF, 32'h11223344, 1'b0);
        do_txn(0, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD, 1'b0);
        do_txn(0, 1'b0, 32'h8, 4'h0, 32'd0, 1'b0);
        drain();

        // Errors, the be=0 no-op, and a load after them
        do_txn(0, 1'b0, 32'h6, 4'hF, 32'd0, 1'b0);
        do_txn(0, 1'b1, 32'h1000, 4'hF, 32'h55AA55AA, 1'b0);
        do_txn(0, 1'b1, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0);
        do_txn(0, 1'b0, 32'h0, 4'hF, 32'd0, 1'b0);
        do_txn(0, 1'b0, 32'hFFC, 4'hF, 32'd0, 1'b0);
        drain();

        // LATENCY=0, req held high across two loads
        do_txn(1, 1'b1, 32'h4, 4'hF, 32'hCAFEF00D, 1'b0);
        drain();
        do_txn(1, 1'b0, 32'h4, 4'hF, 32'd0, 1'b1);
        do_txn(1, 1'b0, 32'h10, 4'hF, 32'd0, 1'b0);
        drain();

        // Reset while the store is in WAIT
        do_txn(0, 1'b1, 32'hC, 4'hF, 32'h12345678, 1'b0);
        @(posedge clk); #1;
        do_reset();
        repeat (6) begin
            @(posedge clk); #1;
        end
        do_txn(0, 1'b0, 32'hC, 4'hF, 32'd0, 1'b0);
        drain();

        // Random traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 40; t++) begin
                case ($urandom_range(0, 9))
                    0:       a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
                    1:       a = ($urandom_range(0, 1) == 0) ? 32'h1000 : ($urandom | 32'h8000_0000);
                    2:       a = 32'hFFC;
                    default: a = 32'($urandom_range(0, 31)) * 4;
                endcase
                do_txn(k, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
                       (k == 1) && (t < 39) && ($urandom_range(0, 1) == 1));
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
